// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_pkg
// Description : Shared types and constants for the CLB bitstream loader.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_pkg;

  // 1 is_comb + 12 connection-select + 16 LUT bits
  localparam int CHAIN_LEN_DEFAULT = 29;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // One serial CRC-8 step, MSB-first register with the feedback bit folded in.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitstream_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : bitstream_loader_if
// Description : Control, byte-stream and scan-chain signals of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface bitstream_loader_if;

  logic       start;
  logic       abort;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       scan_en;
  logic       scan_clk_en;
  logic       scan_out;
  logic       busy;
  logic       done;
  logic       err;

  // Host / bitstream source side
  modport master (
    output start, abort, byte_data, byte_valid,
    input  byte_ready, scan_en, scan_clk_en, scan_out, busy, done, err
  );

  // Loader side
  modport slave (
    input  start, abort, byte_data, byte_valid,
    output byte_ready, scan_en, scan_clk_en, scan_out, busy, done, err
  );

endinterface
`default_nettype wire

// File: rtl/crc8_serial.sv
`default_nettype none
// ============================================================================
// Module      : crc8_serial
// Description : Bit-serial CRC-8 (poly 0x07, init 0x00) accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module crc8_serial
  import cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  // Clear on a new load, otherwise fold in each qualified bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (bit_en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module      : bitstream_loader
// Description : Streams a byte-wide bitstream LSB-first into a CLB scan chain,
//               then checks a trailing CRC-8 byte against the shifted bits.
// Revision    : 1.0 - initial release
// ============================================================================
module bitstream_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  bitstream_loader_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;     // bits presented so far, including the current one
  logic [7:0]       byte_reg;    // not-yet-presented bits of the current byte, LSB next
  logic [3:0]       rem_cnt;     // bits of current byte still occupying the output stage
  logic             scan_en_q;
  logic             scan_clk_en_q;
  logic             scan_out_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [7:0]       crc;

  logic             chain_full;
  logic             byte_ready;
  logic             accept;
  logic             start_ok;

  assign chain_full = (bit_cnt == CNT_W'(CHAIN_LEN));

  // A new byte may land while the last bit of the previous one is on the
  // output, which keeps shifting gap-free; once the chain is full no more
  // data bytes are taken so the CRC byte is never swallowed by LOAD.
  assign byte_ready = ((state == ST_LOAD) && (rem_cnt <= 4'd1) && !chain_full)
                    || (state == ST_CHECK);
  assign accept     = byte_ready && bus.byte_valid;

  // Abort always beats a simultaneous start.
  assign start_ok   = bus.start && !bus.abort &&
                      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

  crc8_serial u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_ok),
    .bit_en (scan_clk_en_q),
    .bit_in (scan_out_q),
    .crc    (crc)
  );

  // Load sequencer: state, byte shifter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      byte_reg      <= 8'h00;
      rem_cnt       <= 4'd0;
      scan_en_q     <= 1'b0;
      scan_clk_en_q <= 1'b0;
      scan_out_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      scan_clk_en_q <= 1'b0;
      scan_out_q    <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_ok) begin
            state     <= ST_LOAD;
            bit_cnt   <= '0;
            byte_reg  <= 8'h00;
            rem_cnt   <= 4'd0;
            scan_en_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (bus.abort) begin
            state     <= ST_IDLE;
            rem_cnt   <= 4'd0;
            byte_reg  <= 8'h00;
            scan_en_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (chain_full) begin
            // Leftover bits of the last byte are dropped here.
            state     <= ST_CHECK;
            rem_cnt   <= 4'd0;
            byte_reg  <= 8'h00;
            scan_en_q <= 1'b0;
          end else if (accept) begin
            scan_out_q    <= bus.byte_data[0];
            scan_clk_en_q <= 1'b1;
            byte_reg      <= {1'b0, bus.byte_data[7:1]};
            rem_cnt       <= 4'd8;
            bit_cnt       <= bit_cnt + CNT_W'(1);
          end else if (rem_cnt > 4'd1) begin
            scan_out_q    <= byte_reg[0];
            scan_clk_en_q <= 1'b1;
            byte_reg      <= {1'b0, byte_reg[7:1]};
            rem_cnt       <= rem_cnt - 4'd1;
            bit_cnt       <= bit_cnt + CNT_W'(1);
          end else begin
            rem_cnt <= 4'd0;
          end
        end
        ST_CHECK: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (accept) begin
            busy_q <= 1'b0;
            if (bus.byte_data == crc) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state <= ST_ERR;
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.byte_ready  = byte_ready;
  assign bus.scan_en     = scan_en_q;
  assign bus.scan_clk_en = scan_clk_en_q;
  assign bus.scan_out    = scan_out_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitstream_loader
// Description : Scoreboard bench for bitstream_loader with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitstream_loader;

  localparam int CHAIN_LEN = 29;
  localparam int NB        = (CHAIN_LEN + 7) / 8;

  typedef struct {
    logic done;
    logic err;
    int   shifts;
  } status_t;

  logic clk = 1'b0;
  logic rst;

  bitstream_loader_if bus();

  bitstream_loader #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int      vectors     = 0;
  int      miscompares = 0;
  logic    exp_bits[$];
  status_t exp_status[$];
  int      avail;
  int      shifted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC-8 poly 0x07 init 0 over the chain bits in shift order.
  function automatic logic [7:0] crc_model(input logic b[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (b[i]) begin
      if (c[7] ^ b[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Monitor: a bit is shifted whenever one is available and the chain is not full.
  initial begin : monitor
    logic    prev_scan_en;
    logic    prev_busy;
    logic    exp_ce;
    logic    exp_rdy;
    status_t s;
    prev_scan_en = 1'b0;
    prev_busy    = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.scan_en && !prev_scan_en) begin
        avail   = 0;
        shifted = 0;
      end
      if (bus.scan_en) begin
        exp_ce  = (avail > 0) && (shifted < CHAIN_LEN);
        exp_rdy = (avail <= 1) && ((shifted + (exp_ce ? 1 : 0)) < CHAIN_LEN);
        chk("scan_clk_en", bus.scan_clk_en, exp_ce);
        chk("byte_ready_load", bus.byte_ready, exp_rdy);
      end else begin
        chk("scan_clk_en_off", bus.scan_clk_en, 1'b0);
        chk("byte_ready_idle", bus.byte_ready, bus.busy);
      end
      if (bus.scan_clk_en) begin
        if (exp_bits.size() == 0) chk("unexpected_shift", 1, 0);
        else                      chk("scan_out", bus.scan_out, exp_bits.pop_front());
        shifted++;
        if (avail > 0) avail--;
      end
      if (bus.scan_en && bus.byte_ready && bus.byte_valid) avail += 8;
      if (prev_busy && !bus.busy) begin
        if (exp_status.size() == 0) begin
          chk("unexpected_status", 1, 0);
        end else begin
          s = exp_status.pop_front();
          chk("status_flags", {bus.done, bus.err}, {s.done, s.err});
          if (s.shifts >= 0) chk("shift_count", shifted, s.shifts);
        end
      end
      prev_scan_en = bus.scan_en;
      prev_busy    = bus.busy;
    end
  end

  // One load: data bits are the stream in shift order (bit n = data[n]).
  task automatic run_load(input logic [31:0] data, input logic [7:0] crc_xor,
                          input int stall_at, input int stall_len, input bit rnd_stall,
                          input int abort_at, input bit use_rst, input bit start_mid);
    logic       bits[$];
    logic [7:0] crc;
    logic [7:0] stim[NB+1];
    int         idx;
    int         cyc;
    int         stall_cnt;
    logic       vnow;
    logic       acc;
    status_t    st;
    for (int i = 0; i < CHAIN_LEN; i++) bits.push_back(data[i]);
    crc = crc_model(bits);
    for (int i = 0; i < NB; i++) stim[i] = data[8*i +: 8];
    stim[NB] = crc ^ crc_xor;
    foreach (bits[i]) exp_bits.push_back(bits[i]);
    st.done   = (abort_at < 0) && (crc_xor == 8'h00);
    st.err    = (abort_at < 0) && (crc_xor != 8'h00);
    st.shifts = (abort_at < 0) ? CHAIN_LEN : -1;
    exp_status.push_back(st);
    shifted = 0;
    avail   = 0;

    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;

    idx = 0; cyc = 0; stall_cnt = 0;
    while (idx <= NB) begin
      if (cyc >= 400) begin
        chk("driver_timeout", idx, NB + 1);
        break;
      end
      if (abort_at >= 0 && shifted >= abort_at) begin
        bus.byte_valid = 1'b0;
        if (use_rst) rst = 1'b1;
        else begin
          bus.abort = 1'b1;
          bus.start = 1'b1;
        end
        @(posedge clk); #1;
        chk(use_rst ? "reset_idle" : "abort_idle",
            {bus.scan_en, bus.scan_clk_en, bus.scan_out, bus.busy,
             bus.done, bus.err, bus.byte_ready}, 0);
        rst       = 1'b0;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        exp_bits.delete();
        @(posedge clk); #1;
        chk("stay_idle", {bus.busy, bus.scan_en}, 0);
        break;
      end
      vnow = 1'b1;
      if (stall_len > 0 && idx == stall_at && stall_cnt < stall_len) begin
        vnow = 1'b0;
        stall_cnt++;
      end else if (rnd_stall && $urandom_range(0, 3) == 0) begin
        vnow = 1'b0;
      end
      bus.byte_valid = vnow;
      bus.byte_data  = vnow ? stim[idx] : 8'($urandom);
      bus.start      = start_mid && (idx == 2);
      acc = bus.byte_ready && vnow;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    bus.byte_valid = 1'b0;
    bus.start      = 1'b0;

    for (int w = 0; w < 50 && exp_status.size() != 0; w++) @(posedge clk);
    #1;
    if (exp_status.size() != 0) begin
      chk("status_timeout", exp_status.size(), 0);
      exp_status.delete();
    end
    chk("bits_left", exp_bits.size(), 0);
    exp_bits.delete();

    // Flags hold and bytes are refused while parked after the load.
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("flag_hold", {bus.done, bus.err}, {st.done, st.err});
    bus.byte_valid = 1'b0;
  endtask

  initial begin : stimulus
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {bus.scan_en, bus.scan_clk_en, bus.scan_out, bus.busy,
                        bus.done, bus.err, bus.byte_ready}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {bus.scan_en, bus.busy, bus.done, bus.err, bus.byte_ready}, 0);

    run_load(32'h0000_0000, 8'h00, -1, 0, 1'b0, -1, 1'b0, 1'b0); // zeros, good CRC
    run_load(32'h0000_0000, 8'h01, -1, 0, 1'b0, -1, 1'b0, 1'b0); // zeros, CRC byte 01
    run_load(32'h0000_0001, 8'h00, -1, 0, 1'b0, -1, 1'b0, 1'b0); // single leading one
    run_load(32'h1B3C_A5C3, 8'h00,  2, 5, 1'b0, -1, 1'b0, 1'b0); // 5-cycle starvation
    run_load(32'hE000_0000, 8'h00, -1, 0, 1'b0, -1, 1'b0, 1'b0); // dropped tail bits
    run_load(32'h5A5A_5A5A, 8'h00, -1, 0, 1'b0, 12, 1'b0, 1'b0); // abort at shift 12
    run_load(32'h0F0F_1234, 8'h00, -1, 0, 1'b0, -1, 1'b0, 1'b0);
    run_load(32'hDEAD_BEEF, 8'h00, -1, 0, 1'b0, 12, 1'b1, 1'b0); // reset at shift 12
    run_load(32'h8765_4321, 8'h00, -1, 0, 1'b0, -1, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_load($urandom,
               ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
               -1, 0, 1'($urandom_range(0, 1)), -1, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/bitstream_loader.md
BITSTREAM_LOADER -- requirements
Module: bitstream_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 29, SHALL be the number of configuration bits in the downstream CLB scan chain (1 is_comb + 12 connection-select + 16 LUT bits).
REQ-002 Parameter CNT_W, default 5, SHALL be the bit-counter width, with 2**CNT_W > CHAIN_LEN.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  SHALL be the reset, asynchronous and active-high.
REQ-005 start  in  1  SHALL be a one-cycle pulse that begins a load.
REQ-006 abort  in  1  SHALL be a synchronous cancel of an active load.
REQ-007 byte_data  in  8  SHALL carry bitstream byte, LSB shifted first.
REQ-008 byte_valid  in  1  SHALL mark byte_data valid.
REQ-009 byte_ready  out  1  SHALL accept byte_data when high together with byte_valid.
REQ-010 scan_en  out  1  SHALL be the chain shift-mode enable.
REQ-011 scan_clk_en  out  1  SHALL qualify the external scan_clk gate; one chain shift per high cycle.
REQ-012 scan_out  out  1  SHALL be the serial bit driven into the chain scan_in.
REQ-013 busy, done, err  out  1 each  SHALL be the status flags.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, CHECK, DONE, ERR.
REQ-015 start in IDLE, DONE or ERR SHALL enter LOAD and clear the bit counter, CRC, done and err; start in LOAD or CHECK SHALL be ignored.
REQ-016 The block SHALL hold one byte register with a remaining-bit count (0..8).
REQ-017 In LOAD, byte_ready SHALL be high when the remaining count is 0 or 1; otherwise low.
REQ-018 A byte accepted in cycle t SHALL have bit 0 presented in cycle t+1, bit k in cycle t+1+k; back-to-back acceptance SHALL give gap-free shifting.
REQ-019 Each presented bit SHALL drive scan_out and scan_clk_en=1 in the same cycle, increment the bit counter, and update the CRC.
REQ-020 scan_clk_en SHALL be 0 in any cycle without a presented bit (input starvation, non-LOAD states).
REQ-021 scan_en SHALL be 1 exactly while in LOAD.
REQ-022 After the bit counter reaches CHAIN_LEN, remaining bits of the current byte SHALL be discarded with no shift, and the FSM SHALL enter CHECK the next cycle.
REQ-023 The CRC SHALL be CRC-8, polynomial 0x07, init 0x00: fb=crc[7]^bit, crc={crc[6:0],0}^(fb?0x07:0x00), over the CHAIN_LEN shifted bits only.
REQ-024 In CHECK, byte_ready SHALL be 1; the accepted byte SHALL equal the CRC for DONE (done=1), else ERR (err=1).
REQ-025 busy SHALL be 1 in LOAD and CHECK only; done and err SHALL hold until the next accepted start.
REQ-026 abort in LOAD or CHECK SHALL go to IDLE the next cycle, with scan_en and scan_clk_en 0, and done and err left 0; abort and start in the same cycle SHALL make abort win.
REQ-027 Bytes offered in IDLE, DONE or ERR SHALL not be accepted (byte_ready=0).

Reset
REQ-028 rst SHALL force IDLE immediately; all outputs, counters, byte register and CRC SHALL reset to 0, including mid-load.
REQ-029 A partially shifted chain after reset or abort SHALL be treated as invalid; only a subsequent complete load SHALL be trusted.

Structure
REQ-030 Shared package cfg_pkg SHALL hold the state enum, CRC8_POLY=8'h07 and the default CHAIN_LEN.
REQ-031 The serial CRC SHALL be a sub-module crc8_serial (clk, rst, clr, bit_en, bit_in, crc).

Verification
REQ-032 start, bytes 00,00,00,00 with valid held high, CRC 00 -> exactly 29 contiguous scan_clk_en cycles starting the cycle after first accept, all scan_out=0, done=1, err=0.
REQ-033 Same stream, CRC byte 01 -> err=1, done=0, busy=0.
REQ-034 Byte 0x01 first, then zeros -> scan_out=1 only on the first shift cycle; chain tail equals 1 after 29 shifts; expected CRC from golden model.
REQ-035 byte_valid deasserted for 5 cycles mid-stream -> scan_clk_en low those cycles, total shifts still 29, CRC unchanged.
REQ-036 Final byte 0xE0 (upper 3 bits beyond CHAIN_LEN) -> no shifts for bits 5..7, CHECK entered, CRC excludes them.
REQ-037 rst or abort asserted at shift 12 -> IDLE, all outputs 0; new start then a full load -> done=1.
